// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit.
// Width defaults, reset vector default and next-PC source encoding.
package pc_unit_pkg;

    localparam int DATAWIDTH_DEF    = 16;
    localparam int IMMWIDTH_DEF     = 8;
    localparam int RAS_DEPTH_DEF    = 4;
    localparam int RESET_VECTOR_DEF = 0;

    // Next-PC source; decode reuses this encoding for tracing.
    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_BR   = 3'd1,
        SEL_JMP  = 3'd2,
        SEL_CALL = 3'd3,
        SEL_RET  = 3'd4
    } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack.
// Push overwrites the oldest entry when full; pop on empty flags underflow.
module pc_ras
    import pc_unit_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF,
    parameter int PW        = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1,
    parameter int CW        = $clog2(RAS_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATAWIDTH-1:0] din,
    output logic [DATAWIDTH-1:0] top,
    output logic [CW-1:0]        count,
    output logic                 ovf,
    output logic                 unf
);

    logic [DATAWIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]        top_ptr;
    logic [PW-1:0]        ptr_inc;
    logic [PW-1:0]        ptr_dec;
    logic                 full;
    logic                 empty;

    // Pointer neighbours wrap modulo depth, which need not be a power of two.
    always_comb begin
        ptr_inc = (top_ptr == PW'(RAS_DEPTH - 1)) ? '0 : top_ptr + 1'b1;
        ptr_dec = (top_ptr == '0) ? PW'(RAS_DEPTH - 1) : top_ptr - 1'b1;
        full    = (count == CW'(RAS_DEPTH));
        empty   = (count == '0);
        top     = empty ? '0 : mem[top_ptr];
    end

    // Stack state; pop wins over push, en low freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
            top_ptr <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else if (en) begin
            if (pop) begin
                if (!empty) begin
                    top_ptr <= ptr_dec;
                    count   <= count - 1'b1;
                end else begin
                    unf <= 1'b1;
                end
            end else if (push) begin
                mem[ptr_inc] <= din;
                top_ptr      <= ptr_inc;
                if (full) ovf <= 1'b1;
                else      count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with branch/jump/call/return redirects.
// Holds the pc register and next-PC mux; return addresses live in pc_ras.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int DATAWIDTH    = DATAWIDTH_DEF,
    parameter int IMMWIDTH     = IMMWIDTH_DEF,
    parameter int RAS_DEPTH    = RAS_DEPTH_DEF,
    parameter int RESET_VECTOR = RESET_VECTOR_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             pcEn,
    input  logic                             branch,
    input  logic                             jump,
    input  logic                             call,
    input  logic                             ret,
    input  logic [IMMWIDTH-1:0]              disp,
    input  logic [DATAWIDTH-1:0]             dDst,
    output logic [DATAWIDTH-1:0]             pc,
    output logic [DATAWIDTH-1:0]             pc_ra,
    output logic [DATAWIDTH-1:0]             pc_next,
    output logic [DATAWIDTH-1:0]             ras_top,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_ovf,
    output logic                             ras_unf
);

    logic [DATAWIDTH-1:0] disp_ext;
    logic [DATAWIDTH-1:0] br_tgt;
    logic                 ras_empty;
    pc_sel_e              sel;

    assign disp_ext  = {{(DATAWIDTH-IMMWIDTH){disp[IMMWIDTH-1]}}, disp};
    assign br_tgt    = pc + disp_ext;
    assign pc_ra     = pc + 1'b1;
    assign ras_empty = (ras_count == '0);

    // Fixed-priority source select: ret > call > jump > branch > sequential.
    always_comb begin
        sel = SEL_SEQ;
        priority case (1'b1)
            ret:     sel = SEL_RET;
            call:    sel = SEL_CALL;
            jump:    sel = SEL_JMP;
            branch:  sel = SEL_BR;
            default: sel = SEL_SEQ;
        endcase
    end

    // Next-PC mux; a ret on an empty stack falls through to pc+1.
    always_comb begin
        pc_next = pc_ra;
        case (sel)
            SEL_RET:  pc_next = ras_empty ? pc_ra : ras_top;
            SEL_CALL: pc_next = dDst;
            SEL_JMP:  pc_next = dDst;
            SEL_BR:   pc_next = br_tgt;
            default:  pc_next = pc_ra;
        endcase
    end

    // PC register; reset overrides the enable.
    always_ff @(posedge clk) begin
        if (rst)       pc <= DATAWIDTH'(RESET_VECTOR);
        else if (pcEn) pc <= pc_next;
    end

    pc_ras #(
        .DATAWIDTH (DATAWIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .en    (pcEn),
        .push  (call && !ret),
        .pop   (ret),
        .din   (pc_ra),
        .top   (ras_top),
        .count (ras_count),
        .ovf   (ras_ovf),
        .unf   (ras_unf)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed steps plus randomized traffic
// checked against a queue-based model of the pc and return stack.
module tb_pc_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcEn;
    logic        branch;
    logic        jump;
    logic        call;
    logic        ret;
    logic [7:0]  disp;
    logic [15:0] dDst;
    logic [15:0] pc;
    logic [15:0] pc_ra;
    logic [15:0] pc_next;
    logic [15:0] ras_top;
    logic [2:0]  ras_count;
    logic        ras_ovf;
    logic        ras_unf;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_pc;
    logic [15:0] m_stk [$];
    logic        m_ovf;
    logic        m_unf;

    pc_unit dut (
        .clk       (clk),
        .rst       (rst),
        .pcEn      (pcEn),
        .branch    (branch),
        .jump      (jump),
        .call      (call),
        .ret       (ret),
        .disp      (disp),
        .dDst      (dDst),
        .pc        (pc),
        .pc_ra     (pc_ra),
        .pc_next   (pc_next),
        .ras_top   (ras_top),
        .ras_count (ras_count),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] add16(input logic [15:0] a, input int b);
        int s;
        s = int'(a) + b;
        return 16'(s & 32'hFFFF);
    endfunction

    function automatic logic [15:0] model_next();
        int sd;
        sd = (int'(disp) > 127) ? int'(disp) - 256 : int'(disp);
        if (ret) return (m_stk.size() > 0) ? m_stk[$] : add16(m_pc, 1);
        if (call || jump) return dDst;
        if (branch) return add16(m_pc, sd);
        return add16(m_pc, 1);
    endfunction

    task automatic model_edge(input logic [15:0] np);
        if (rst) begin
            m_pc = 16'h0000;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (pcEn) begin
            if (ret) begin
                if (m_stk.size() > 0) void'(m_stk.pop_back());
                else m_unf = 1'b1;
            end else if (call) begin
                m_stk.push_back(add16(m_pc, 1));
                if (m_stk.size() > DEPTH) begin
                    void'(m_stk.pop_front());
                    m_ovf = 1'b1;
                end
            end
            m_pc = np;
        end
    endtask

    task automatic check_state();
        chk("pc", pc, m_pc);
        chk("pc_ra", pc_ra, add16(m_pc, 1));
        chk("ras_count", ras_count, m_stk.size());
        chk("ras_top", ras_top, (m_stk.size() > 0) ? m_stk[$] : 16'h0);
        chk("ras_ovf", ras_ovf, m_ovf);
        chk("ras_unf", ras_unf, m_unf);
    endtask

    task automatic cyc(input logic r, input logic en, input logic br,
                       input logic jp, input logic cl, input logic rt,
                       input logic [7:0] d, input logic [15:0] dst);
        logic [15:0] np;
        rst = r; pcEn = en; branch = br; jump = jp;
        call = cl; ret = rt; disp = d; dDst = dst;
        #1;
        np = model_next();
        if (!r) chk("pc_next", pc_next, np);
        @(posedge clk);
        model_edge(np);
        #1;
        check_state();
    endtask

    task automatic seq();        cyc(0,1,0,0,0,0,8'h0,16'h0); endtask
    task automatic jmp(input logic [15:0] t); cyc(0,1,0,1,0,0,8'h0,t); endtask
    task automatic cll(input logic [15:0] t); cyc(0,1,0,0,1,0,8'h0,t); endtask
    task automatic rtn();        cyc(0,1,0,0,0,1,8'h0,16'h0); endtask
    task automatic bra(input logic [7:0] d);  cyc(0,1,1,0,0,0,d,16'h0); endtask
    task automatic rstc();       cyc(1,0,0,0,0,0,8'h0,16'h0); endtask

    initial begin
        m_pc = 16'h0; m_ovf = 1'b0; m_unf = 1'b0;
        rst = 1'b1; pcEn = 1'b0; branch = 1'b0; jump = 1'b0;
        call = 1'b0; ret = 1'b0; disp = 8'h0; dDst = 16'h0;

        // 1. reset then sequential
        rstc();
        chk("reset_pc", pc, 16'h0000);
        seq(); chk("seq1", pc, 16'h0001);
        seq(); chk("seq2", pc, 16'h0002);
        seq(); chk("seq3", pc, 16'h0003);

        // 2. branches and wrap
        jmp(16'h0010);
        bra(8'hFE); chk("br_neg", pc, 16'h000E);
        bra(8'h7F); chk("br_pos", pc, 16'h008D);
        jmp(16'hFFFF);
        seq(); chk("wrap", pc, 16'h0000);

        // 3. call/ret
        jmp(16'h0020);
        cll(16'h0100); chk("call_pc", pc, 16'h0100);
        chk("call_top", ras_top, 16'h0021);
        rtn(); chk("ret_pc", pc, 16'h0021);
        chk("ret_cnt", ras_count, 3'd0);

        // 4. overflow then underflow
        rstc();
        for (int i = 1; i <= 5; i++) cll(16'(i));
        chk("ovf_cnt", ras_count, 3'd4);
        chk("ovf_flag", ras_ovf, 1'b1);
        for (int i = 5; i >= 2; i--) begin
            rtn(); chk("ovf_ret", pc, 16'(i));
        end
        rtn(); chk("unf_pc", pc, 16'h0003);
        chk("unf_flag", ras_unf, 1'b1);

        // 5. simultaneous controls
        rstc();
        jmp(16'h003F);
        cll(16'h0080);
        cyc(0,1,1,0,1,1,8'h10,16'h0300);
        chk("prio_ret", pc, 16'h0040);
        chk("prio_nopush", ras_count, 3'd0);
        cyc(0,1,1,1,0,0,8'h10,16'h0200);
        chk("prio_jmp", pc, 16'h0200);

        // 6. stall and reset under stall
        cll(16'h0300);
        for (int i = 0; i < 3; i++) cyc(0,0,0,0,1,0,8'h0,16'h0500);
        chk("stall_pc", pc, 16'h0300);
        chk("stall_cnt", ras_count, 3'd1);
        for (int i = 0; i < 4; i++) cll(16'h0400 + 16'(i));
        rtn(); rtn();
        chk("pre_rst_cnt", ras_count, 3'd2);
        chk("pre_rst_ovf", ras_ovf, 1'b1);
        rstc();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_cnt", ras_count, 3'd0);
        chk("rst_ovf", ras_ovf, 1'b0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 49) == 0),
                ($urandom_range(0, 7) != 0),
                1'($urandom), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                8'($urandom), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
